// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci range-scan slice.
// Contents: value width of the detector bus and the scan FSM state encoding.
package fib_pkg;

   localparam int FIB_W = 4;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SCAN = 2'd1,
      ST_DONE = 2'd2
   } state_t;

endpackage : fib_pkg

// File: rtl/isfib_muxb_8_1.sv
// 4-bit Fibonacci detector built as an 8:1 mux.
// v[3:1] selects a leg; each leg is 0, 1, v[0] or ~v[0], which covers
// the set {0,1,2,3,5,8,13}.
// Ports:
//   v   - value under test
//   fib - high when v is a Fibonacci number
module isfib_muxb_8_1
   import fib_pkg::*;
(
   input  logic [FIB_W-1:0] v,
   output logic             fib
);

   // Mux leg selection on the upper three bits, low bit as data.
   always_comb begin
      fib = 1'b0;
      case (v[3:1])
         3'd0:    fib = 1'b1;    // 0, 1
         3'd1:    fib = 1'b1;    // 2, 3
         3'd2:    fib = v[0];    // 5
         3'd3:    fib = 1'b0;    // 6, 7
         3'd4:    fib = ~v[0];   // 8
         3'd5:    fib = 1'b0;    // 10, 11
         3'd6:    fib = v[0];    // 13
         3'd7:    fib = 1'b0;    // 14, 15
         default: fib = 1'b0;
      endcase
   end

endmodule : isfib_muxb_8_1

// File: rtl/fib_range_scan.sv
// Sequential sweep feeding the Fibonacci detector: on start, steps cur from
// lo to hi inclusive (one value per clock) and counts detector hits.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   start      - scan request, only honoured in IDLE
//   lo, hi     - inclusive range, latched when start is accepted
//   cur        - value currently presented to the detector
//   busy       - high while scanning
//   done       - one-cycle completion pulse
//   count      - number of Fibonacci values in the range (held until next scan)
module fib_range_scan
   import fib_pkg::*;
#(
   parameter int CW = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [FIB_W-1:0] lo,
   input  logic [FIB_W-1:0] hi,
   output logic [FIB_W-1:0] cur,
   output logic             busy,
   output logic             done,
   output logic [CW-1:0]    count
);

   state_t           state_r;
   logic [FIB_W-1:0] cur_r;
   logic [FIB_W-1:0] hi_q_r;
   logic [CW-1:0]    count_r;
   logic             hit_s;

   isfib_muxb_8_1 u_isfib (
      .v   (cur_r),
      .fib (hit_s)
   );

   // Scan FSM with its datapath registers; equality stop on hi_q avoids wrap at 15.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
         cur_r   <= {FIB_W{1'b0}};
         hi_q_r  <= {FIB_W{1'b0}};
         count_r <= {CW{1'b0}};
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start) begin
                  cur_r   <= lo;
                  hi_q_r  <= hi;
                  count_r <= {CW{1'b0}};
                  // An empty range skips scanning but still reports done.
                  state_r <= (lo <= hi) ? ST_SCAN : ST_DONE;
               end else begin
                  state_r <= ST_IDLE;
               end
            end
            ST_SCAN: begin
               count_r <= count_r + {{(CW-1){1'b0}}, hit_s};
               if (cur_r == hi_q_r) begin
                  state_r <= ST_DONE;
               end else begin
                  cur_r   <= cur_r + {{(FIB_W-1){1'b0}}, 1'b1};
                  state_r <= ST_SCAN;
               end
            end
            ST_DONE: begin
               state_r <= ST_IDLE;
            end
            default: begin
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

   // Status flags are pure state decodes so start has no combinational path out.
   always_comb begin
      busy  = (state_r == ST_SCAN);
      done  = (state_r == ST_DONE);
      cur   = cur_r;
      count = count_r;
   end

endmodule : fib_range_scan

// File: tb/tb_fib_range_scan.sv
// Self-checking bench for fib_range_scan: table vectors, randomized ranges
// against a set-membership model, and hand sequences for ignored start,
// mid-scan reset and continuous re-trigger.
module tb_fib_range_scan;

   localparam int CW = 5;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          start = 1'b0;
   logic [3:0]    lo = 4'd0;
   logic [3:0]    hi = 4'd0;
   logic [3:0]    cur;
   logic          busy;
   logic          done;
   logic [CW-1:0] count;

   int n_checks = 0;
   int n_fail   = 0;

   fib_range_scan #(.CW(CW)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .start (start),
      .lo    (lo),
      .hi    (hi),
      .cur   (cur),
      .busy  (busy),
      .done  (done),
      .count (count)
   );

   always #5 clk = ~clk;

   typedef struct {
      int lo;
      int hi;
      int exp_count;
      int exp_edges;
      int exp_cur;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Reference: count members of the Fibonacci set inside [l,h].
   function automatic int model_count(input int l, input int h);
      int fibs[7] = '{0, 1, 2, 3, 5, 8, 13};
      int c = 0;
      for (int v = l; v <= h; v++)
         foreach (fibs[j])
            if (fibs[j] == v) c++;
      return c;
   endfunction

   // Launch one scan and check timing, busy length, final count/cur and hold.
   task automatic run_scan(input int l, input int h, input int exp_cnt, input int exp_edges,
                           input int exp_cur, input int repulse_at, input string tag);
      int edges = 0;
      int busy_cyc = 0;
      bit found = 1'b0;
      @(negedge clk);
      lo = l[3:0]; hi = h[3:0]; start = 1'b1;
      @(posedge clk);               // E0
      @(negedge clk);
      start = 1'b0;
      while (edges < 40 && !found) begin
         if (done) begin
            found = 1'b1;
         end else begin
            if (busy) busy_cyc++;
            if (edges == repulse_at) begin
               start = 1'b1; lo = 4'd14; hi = 4'd15;
            end
            @(posedge clk);
            edges++;
            @(negedge clk);
            start = 1'b0;
         end
      end
      check({tag, "_done_seen"}, 32'(found), 32'd1);
      check({tag, "_done_edges"}, edges, exp_edges);
      check({tag, "_busy_cycles"}, busy_cyc, exp_edges);
      check({tag, "_count"}, 32'(count), exp_cnt);
      check({tag, "_cur"}, 32'(cur), exp_cur);
      @(posedge clk);
      @(negedge clk);
      check({tag, "_done_pulse_len"}, 32'(done), 32'd0);
      check({tag, "_idle_busy"}, 32'(busy), 32'd0);
      check({tag, "_count_hold"}, 32'(count), exp_cnt);
      check({tag, "_cur_hold"}, 32'(cur), exp_cur);
   endtask

   initial begin
      vec_t vecs[5];
      int   t1, t2, cyc;
      vecs[0] = '{lo: 0,  hi: 15, exp_count: 7, exp_edges: 16, exp_cur: 15};
      vecs[1] = '{lo: 4,  hi: 7,  exp_count: 1, exp_edges: 4,  exp_cur: 7};
      vecs[2] = '{lo: 9,  hi: 12, exp_count: 0, exp_edges: 4,  exp_cur: 12};
      vecs[3] = '{lo: 13, hi: 13, exp_count: 1, exp_edges: 1,  exp_cur: 13};
      vecs[4] = '{lo: 10, hi: 2,  exp_count: 0, exp_edges: 0,  exp_cur: 10};

      // Reset state.
      #12;
      check("rst_cur", 32'(cur), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_count", 32'(count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i])
         run_scan(vecs[i].lo, vecs[i].hi, vecs[i].exp_count, vecs[i].exp_edges,
                  vecs[i].exp_cur, -1, $sformatf("vec%0d", i));

      // Randomized ranges against the model.
      for (int r = 0; r < 20; r++) begin
         int l = int'($urandom_range(0, 15));
         int h = int'($urandom_range(0, 15));
         run_scan(l, h, model_count(l, h), (l > h) ? 0 : h - l + 1,
                  (l > h) ? l : h, -1, $sformatf("rnd%0d", r));
      end

      // Start re-pulsed mid-scan with a different range is ignored.
      run_scan(0, 15, 7, 16, 15, 3, "ignore_start");

      // Asynchronous reset in the middle of a scan.
      @(negedge clk);
      lo = 4'd0; hi = 4'd15; start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (7) @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("midrst_cur", 32'(cur), 32'd0);
      check("midrst_busy", 32'(busy), 32'd0);
      check("midrst_done", 32'(done), 32'd0);
      check("midrst_count", 32'(count), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("postrst_idle_busy", 32'(busy), 32'd0);
      run_scan(0, 3, 4, 4, 3, -1, "post_rst");

      // Start held high re-triggers every N+2 cycles (N=3 here).
      @(negedge clk);
      lo = 4'd2; hi = 4'd4; start = 1'b1;
      t1 = -1; t2 = -1; cyc = 0;
      while (cyc < 60 && t2 < 0) begin
         @(posedge clk);
         @(negedge clk);
         cyc++;
         if (done) begin
            if (t1 < 0) t1 = cyc;
            else t2 = cyc;
         end
      end
      start = 1'b0;
      check("retrigger_seen", 32'(t2 >= 0), 32'd1);
      check("retrigger_period", t2 - t1, 32'd5);
      check("retrigger_count", 32'(count), model_count(2, 4));
      repeat (6) @(negedge clk);
      check("retrigger_stop_busy", 32'(busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule : tb_fib_range_scan
